// File: rtl/axon_pe_acc.sv
// axon_pe_acc: output-stationary systolic processing element for the AXON array.
// Registers and forwards ifmap/weight operands to neighbouring PEs. Accumulates
// k_len signed fixed-point products into a wide accumulator. Requantises the
// sum with an arithmetic shift plus saturation, then ejects it into the
// vertical output chain.
module axon_pe_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,   // must be >= 2*DATA_WIDTH
    parameter int FRAC_BITS  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ifmap_in_nbr,
    input  logic [DATA_WIDTH-1:0] ifmap_in_sram,
    input  logic                  ifmap_in_sel,
    input  logic                  ifmap_valid_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  weight_valid_in,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  k_len,
    input  logic [DATA_WIDTH-1:0] output_in,
    input  logic                  output_valid_in,
    input  logic                  output_eject_ctrl,
    output logic [DATA_WIDTH-1:0] ifmap_out,
    output logic                  ifmap_valid_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  weight_valid_out,
    output logic [DATA_WIDTH-1:0] output_out,
    output logic                  output_valid_out,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Saturation bounds, sign-extended to the accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Operand forwarding registers (also the MAC operands).
    logic [DATA_WIDTH-1:0]         ifmap_reg;
    logic                          ifmap_valid_reg;
    logic [DATA_WIDTH-1:0]         weight_reg;
    logic                          weight_valid_reg;

    // Job state.
    state_t                        state_reg, state_next;
    logic signed [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_WIDTH-1:0]          cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0]          k_len_reg, k_len_next;

    // Output chain registers.
    logic [DATA_WIDTH-1:0]         out_reg;
    logic                          out_valid_reg;
    logic                          sat_reg;

    // Datapath.
    logic                          fire;
    logic                          eject;
    logic                          launch;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]          prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_sh;
    logic [DATA_WIDTH-1:0]         res;
    logic                          res_sat;

    // Register the selected ifmap and the weight every cycle, whatever the job state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifmap_reg        <= '0;
            ifmap_valid_reg  <= 1'b0;
            weight_reg       <= '0;
            weight_valid_reg <= 1'b0;
        end else begin
            ifmap_reg        <= ifmap_in_sel ? ifmap_in_sram : ifmap_in_nbr;
            ifmap_valid_reg  <= ifmap_valid_in;
            weight_reg       <= weight_in;
            weight_valid_reg <= weight_valid_in;
        end
    end

    assign ifmap_out        = ifmap_reg;
    assign ifmap_valid_out  = ifmap_valid_reg;
    assign weight_out       = weight_reg;
    assign weight_valid_out = weight_valid_reg;

    // A MAC happens only while accumulating and when both registered operands are valid.
    assign fire = (state_reg == ACCUM) && ifmap_valid_reg && weight_valid_reg;

    // Full-precision signed product of the registered operands.
    assign prod = $signed(ifmap_reg) * $signed(weight_reg);

    // Sign-extend the product to the accumulator width bit by bit, so that
    // ACC_WIDTH == 2*DATA_WIDTH needs no zero-width replication.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_prod_ext
            if (gi < 2*DATA_WIDTH) begin : g_lo
                assign prod_ext[gi] = prod[gi];
            end else begin : g_hi
                assign prod_ext[gi] = prod[2*DATA_WIDTH-1];
            end
        end
    endgenerate

    // The accumulator wraps modulo 2^ACC_WIDTH; it does not saturate.
    assign acc_sum = acc_reg + $signed(prod_ext);

    // Drop the fractional bits, keeping the sign.
    assign acc_sh = acc_reg >>> FRAC_BITS;

    // Clamp the shifted accumulator into the output range and flag clipping.
    always_comb begin
        res     = acc_sh[DATA_WIDTH-1:0];
        res_sat = 1'b0;
        if (acc_sh > RES_MAX) begin
            res     = RES_MAX[DATA_WIDTH-1:0];
            res_sat = 1'b1;
        end else if (acc_sh < RES_MIN) begin
            res     = RES_MIN[DATA_WIDTH-1:0];
            res_sat = 1'b1;
        end
    end

    // Job FSM: next state, accumulator, MAC counter and the eject decision.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        k_len_next = k_len_reg;
        eject      = 1'b0;
        launch     = 1'b0;

        case (state_reg)
            IDLE: begin
                launch = start;
            end
            ACCUM: begin
                // start is deliberately ignored while a job is in flight.
                if (fire) begin
                    acc_next = acc_sum;
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                    if (cnt_reg == k_len_reg - CNT_WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // The result is held until ejected; ejecting with start
                // launches the next job in the same cycle.
                if (output_eject_ctrl) begin
                    eject      = 1'b1;
                    launch     = start;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Launching a job clears the accumulator and latches its length.
        // A zero-length job goes straight to DONE with a zero result.
        if (launch) begin
            acc_next   = '0;
            cnt_next   = '0;
            k_len_next = k_len;
            state_next = (k_len == '0) ? DONE : ACCUM;
        end
    end

    // Job state registers; reset discards any partial accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            k_len_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            k_len_reg <= k_len_next;
        end
    end

    // Output chain: insert our result when ejecting, otherwise pass upstream data through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
        end else if (eject) begin
            out_reg       <= res;
            out_valid_reg <= 1'b1;
            sat_reg       <= res_sat;
        end else begin
            out_reg       <= output_in;
            out_valid_reg <= output_valid_in;
        end
    end

    assign output_out       = out_reg;
    assign output_valid_out = out_valid_reg;
    assign sat_flag         = sat_reg;
    assign busy             = (state_reg != IDLE);
    assign done             = (state_reg == DONE);

endmodule

// File: tb/tb_axon_pe_acc.sv
// Testbench for axon_pe_acc. Drives randomized jobs and checks them with a
// job-level arithmetic reference model. Expected output-chain words go into a
// scoreboard queue, and an independent monitor pops and compares them.
module tb_axon_pe_acc;

    logic        clk;
    logic        rst_n;
    logic [15:0] ifmap_in_nbr;
    logic [15:0] ifmap_in_sram;
    logic        ifmap_in_sel;
    logic        ifmap_valid_in;
    logic [15:0] weight_in;
    logic        weight_valid_in;
    logic        start;
    logic [7:0]  k_len;
    logic [15:0] output_in;
    logic        output_valid_in;
    logic        output_eject_ctrl;
    logic [15:0] ifmap_out;
    logic        ifmap_valid_out;
    logic [15:0] weight_out;
    logic        weight_valid_out;
    logic [15:0] output_out;
    logic        output_valid_out;
    logic        busy;
    logic        done;
    logic        sat_flag;

    axon_pe_acc dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ifmap_in_nbr      (ifmap_in_nbr),
        .ifmap_in_sram     (ifmap_in_sram),
        .ifmap_in_sel      (ifmap_in_sel),
        .ifmap_valid_in    (ifmap_valid_in),
        .weight_in         (weight_in),
        .weight_valid_in   (weight_valid_in),
        .start             (start),
        .k_len             (k_len),
        .output_in         (output_in),
        .output_valid_in   (output_valid_in),
        .output_eject_ctrl (output_eject_ctrl),
        .ifmap_out         (ifmap_out),
        .ifmap_valid_out   (ifmap_valid_out),
        .weight_out        (weight_out),
        .weight_valid_out  (weight_valid_out),
        .output_out        (output_out),
        .output_valid_out  (output_valid_out),
        .busy              (busy),
        .done              (done),
        .sat_flag          (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } exp_t;

    exp_t exp_q[$];
    logic sat_last;
    int   n_vec;
    int   n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: sum of products wrapped to 40 bits, scaled by 2^-8, clamped to 16 bits.
    function automatic void ref_result(input longint sum, output logic [15:0] r, output logic s);
        longint a;
        longint sh;
        a  = (sum <<< 24) >>> 24;
        sh = a >>> 8;
        if (sh > 32767) begin
            r = 16'h7FFF; s = 1'b1;
        end else if (sh < -32768) begin
            r = 16'h8000; s = 1'b1;
        end else begin
            r = 16'(sh); s = 1'b0;
        end
    endfunction

    function automatic longint mul16(input logic [15:0] a, input logic [15:0] b);
        return longint'(shortint'(a)) * longint'(shortint'(b));
    endfunction

    function automatic logic [15:0] pick(input int mode, input logic [15:0] f);
        case (mode)
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 1023)) - 16'd512;
            2:       return f;
            default: return ($urandom % 2 == 1) ? 16'h7FFF : 16'h8000;
        endcase
    endfunction

    // One clock cycle: fill in the chain input, record what the chain should show next, advance.
    task automatic tick(input bit ej_done, input logic [15:0] r, input logic s);
        output_in = 16'($urandom);
        if (ej_done) begin
            output_valid_in = 1'($urandom);
            exp_q.push_back('{d: r, s: s});
            sat_last = s;
        end else begin
            output_valid_in = ($urandom % 3 == 0);
            if (output_valid_in) exp_q.push_back('{d: output_in, s: sat_last});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_operands(input int mode, input logic [15:0] fa, input logic [15:0] fb,
                                input bit iv, input bit wv);
        logic [15:0] a;
        a = pick(mode, fa);
        ifmap_in_sel = 1'($urandom);
        if (ifmap_in_sel) begin
            ifmap_in_sram = a; ifmap_in_nbr = 16'($urandom);
        end else begin
            ifmap_in_nbr = a; ifmap_in_sram = 16'($urandom);
        end
        weight_in       = pick(mode, fb);
        ifmap_valid_in  = iv;
        weight_valid_in = wv;
    endtask

    // Run a whole job: launch (unless already launched by a back-to-back eject),
    // feed k operand pairs with random bubbles, idle in DONE, then eject.
    task automatic run_job(input int k, input int mode, input logic [15:0] fa, input logic [15:0] fb,
                           input bit started, input bit b2b, input int next_k);
        longint      sum;
        int          fired;
        bit          iv;
        bit          wv;
        logic [15:0] r;
        logic        s;
        sum   = 0;
        fired = 0;
        if (!started) begin
            start = 1'b1; k_len = 8'(k);
            ifmap_valid_in = 1'b0; weight_valid_in = 1'b0;
            output_eject_ctrl = 1'($urandom);
            tick(0, 16'h0, 1'b0);
            start = 1'b0;
        end
        if (k > 0) begin
            while (fired < k) begin
                iv = ($urandom % 4 != 0);
                wv = ($urandom % 4 != 0);
                set_operands(mode, fa, fb, iv, wv);
                if (iv && wv) begin
                    fired++;
                    sum += mul16(ifmap_in_sel ? ifmap_in_sram : ifmap_in_nbr, weight_in);
                end
                start = ($urandom % 5 == 0);
                k_len = 8'($urandom);
                output_eject_ctrl = 1'($urandom);
                chk("accum_busy", 64'(busy), 64'd1);
                chk("accum_not_done", 64'(done), 64'd0);
                tick(0, 16'h0, 1'b0);
            end
            ifmap_valid_in = 1'b0; weight_valid_in = 1'b0; start = 1'b0;
            output_eject_ctrl = 1'($urandom);
            chk("last_fire_pending", 64'(done), 64'd0);
            tick(0, 16'h0, 1'b0);
        end
        chk("done_asserted", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        repeat ($urandom % 3) begin
            set_operands(0, 16'h0, 16'h0, 1'($urandom), 1'($urandom));
            output_eject_ctrl = 1'b0;
            start = 1'($urandom);
            k_len = 8'($urandom);
            tick(0, 16'h0, 1'b0);
            chk("done_held", 64'(done), 64'd1);
        end
        ref_result(sum, r, s);
        $display("job k=%0d mode=%0d b2b=%0d expect result=%h sat=%0d", k, mode, b2b, r, s);
        ifmap_valid_in = 1'b0; weight_valid_in = 1'b0;
        output_eject_ctrl = 1'b1;
        start = b2b;
        k_len = 8'(next_k);
        tick(1, r, s);
        output_eject_ctrl = 1'b0;
        start = 1'b0;
        if (b2b) begin
            chk("b2b_busy", 64'(busy), 64'd1);
            chk("b2b_done", 64'(done), (next_k == 0) ? 64'd1 : 64'd0);
        end else begin
            chk("eject_idle", 64'(busy), 64'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifmap_out"}, 64'(ifmap_out), 64'd0);
        chk({tag, "_ifmap_v"}, 64'(ifmap_valid_out), 64'd0);
        chk({tag, "_weight_out"}, 64'(weight_out), 64'd0);
        chk({tag, "_weight_v"}, 64'(weight_valid_out), 64'd0);
        chk({tag, "_output_out"}, 64'(output_out), 64'd0);
        chk({tag, "_output_v"}, 64'(output_valid_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
    endtask

    // Forwarding reference: what the operand outputs must show after each edge.
    logic [15:0] fwd_if;
    logic [15:0] fwd_w;
    logic        fwd_iv;
    logic        fwd_wv;
    logic        fwd_arm;
    always @(posedge clk) begin
        fwd_if  <= ifmap_in_sel ? ifmap_in_sram : ifmap_in_nbr;
        fwd_iv  <= ifmap_valid_in;
        fwd_w   <= weight_in;
        fwd_wv  <= weight_valid_in;
        fwd_arm <= rst_n;
    end

    always @(negedge clk) begin
        if (fwd_arm === 1'b1 && rst_n) begin
            chk("fwd_ifmap", 64'(ifmap_out), 64'(fwd_if));
            chk("fwd_ifmap_v", 64'(ifmap_valid_out), 64'(fwd_iv));
            chk("fwd_weight", 64'(weight_out), 64'(fwd_w));
            chk("fwd_weight_v", 64'(weight_valid_out), 64'(fwd_wv));
        end
    end

    // Output-chain monitor: each valid word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && output_valid_out) begin
            if (exp_q.size() == 0) begin
                chk("chain_unexpected_valid", 64'(output_valid_out), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("chain_data", 64'(output_out), 64'(e.d));
                chk("chain_sat_flag", 64'(sat_flag), 64'(e.s));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        int k;
        int nk;
        bit b2b;
        n_vec = 0; n_bad = 0; sat_last = 1'b0;
        rst_n = 1'b0;
        ifmap_in_nbr = '0; ifmap_in_sram = '0; ifmap_in_sel = 1'b0; ifmap_valid_in = 1'b0;
        weight_in = '0; weight_valid_in = 1'b0; start = 1'b0; k_len = '0;
        output_in = '0; output_valid_in = 1'b0; output_eject_ctrl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a job after two fires, then a single-MAC job.
        start = 1'b1; k_len = 8'd5;
        tick(0, 16'h0, 1'b0);
        start = 1'b0;
        ifmap_in_sel = 1'b1; ifmap_in_sram = 16'h0100; weight_in = 16'h0300;
        ifmap_valid_in = 1'b1; weight_valid_in = 1'b1;
        tick(0, 16'h0, 1'b0);
        tick(0, 16'h0, 1'b0);
        ifmap_valid_in = 1'b0; weight_valid_in = 1'b0;
        tick(0, 16'h0, 1'b0);
        chk("mid_job_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        sat_last = 1'b0;
        output_valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(1, 1, 16'h0, 16'h0, 0, 0, 0);

        // Directed jobs: basic MAC, saturation both ways, zero-length with back-to-back restart.
        run_job(4, 2, 16'h0100, 16'h0200, 0, 0, 0);
        run_job(3, 2, 16'hFF00, 16'h0100, 0, 0, 0);
        run_job(4, 2, 16'h7FFF, 16'h7FFF, 0, 0, 0);
        run_job(4, 2, 16'h8000, 16'h7FFF, 0, 0, 0);
        run_job(0, 0, 16'h0, 16'h0, 0, 1, 2);
        run_job(2, 1, 16'h0, 16'h0, 1, 0, 0);
        run_job(255, 3, 16'h0, 16'h0, 0, 0, 0);

        // Randomized jobs with random back-to-back chaining and idle gaps.
        st = 1'b0;
        k  = $urandom_range(0, 12);
        for (int i = 0; i < 60; i++) begin
            nk  = ($urandom % 6 == 0) ? 0 : $urandom_range(1, 12);
            b2b = (i != 59) && ($urandom % 3 == 0);
            run_job(k, $urandom_range(0, 3), 16'h0, 16'h0, st, b2b, nk);
            st = b2b;
            k  = b2b ? nk : $urandom_range(0, 12);
            if (!b2b) begin
                repeat ($urandom % 3) begin
                    output_eject_ctrl = 1'($urandom);
                    set_operands(0, 16'h0, 16'h0, 1'($urandom), 1'($urandom));
                    tick(0, 16'h0, 1'b0);
                    chk("idle_busy", 64'(busy), 64'd0);
                end
                output_eject_ctrl = 1'b0;
            end
        end

        output_valid_in = 1'b0;
        output_eject_ctrl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
